// File: rtl/ipr_write_master_pkg.sv
// Shared IPR definitions: write-master FSM states and responder register map.
package ipr_write_master_pkg;

  typedef enum logic [1:0] {
    IPR_WM_IDLE = 2'd0,
    IPR_WM_REQ  = 2'd1,
    IPR_WM_RESP = 2'd2
  } ipr_wm_state_e;

  localparam logic [31:0] IPR_REG_DATA  = 32'h0000_0000;
  localparam logic [31:0] IPR_REG_FULL  = 32'h0000_0004;
  localparam logic [31:0] IPR_REG_EMPTY = 32'h0000_0008;

  function automatic logic [31:0] ipr_reg_addr(input logic [31:0] base, input logic [31:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/ipr_write_master_if.sv
// IPR write port: req held until gnt, then one rvalid cycle from the responder.
interface ipr_write_master_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;

  modport master (output req, we, addr, wdata, input gnt, rvalid);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/ipr_write_master_skid.sv
// Two-entry input FIFO for the write master; ready is registered (= not full next cycle).
module ipr_write_master_skid #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              w_clk,
  input  logic              w_rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              ready,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;
  logic              ready_q;
  logic              do_push, do_pop;

  assign do_push = push && ready_q;
  assign do_pop  = pop && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 2'd1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != 2'd2);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign ready = ready_q;
  assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/ipr_write_master.sv
// IPR write initiator: drains a local stream into single-word writes to the IPR DATA register,
// counting completed words/bulks and flagging grant timeouts and response protocol errors.
module ipr_write_master
  import ipr_write_master_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned BULK_NUMBER = 10,
  parameter int unsigned GNT_TIMEOUT = 256
) (
  input  logic                w_clk,
  input  logic                w_rst_n,
  input  logic                en,
  input  logic                s_valid,
  input  logic [DATA_W-1:0]   s_data,
  output logic                s_ready,
  ipr_write_master_if.master  ipr,
  output logic                busy,
  output logic                bulk_done,
  output logic [31:0]         words_sent,
  output logic                err_timeout,
  output logic                err_proto,
  input  logic                err_clr
);

  localparam int unsigned BulkW = (BULK_NUMBER > 1) ? $clog2(BULK_NUMBER) : 1;
  localparam int unsigned ToW   = $clog2(GNT_TIMEOUT + 1);

  ipr_wm_state_e     state_q, state_d;
  logic              req_q;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [BulkW-1:0]  bulk_cnt_q, bulk_cnt_d;
  logic              bulk_done_q, bulk_done_d;
  logic [31:0]       words_q, words_d;
  logic              err_to_q, err_to_d, err_to_set;
  logic              err_pr_q, err_pr_d, err_pr_set;
  logic              buf_empty, pop;
  logic [DATA_W-1:0] buf_head;

  assign pop = req_q && ipr.gnt;

  ipr_write_master_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .w_clk     (w_clk),
    .w_rst_n   (w_rst_n),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (pop),
    .head      (buf_head),
    .ready     (s_ready),
    .empty     (buf_empty)
  );

  always_comb begin
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    bulk_cnt_d  = bulk_cnt_q;
    bulk_done_d = 1'b0;
    words_d     = words_q;
    err_to_set  = 1'b0;
    err_pr_set  = 1'b0;
    unique case (state_q)
      IPR_WM_IDLE: begin
        err_pr_set = ipr.rvalid;
        if (en && !buf_empty) state_d = IPR_WM_REQ;
      end
      IPR_WM_REQ: begin
        // en is ignored here: the responder may already have latched the write.
        err_pr_set = ipr.rvalid;
        if (ipr.gnt) begin
          state_d  = IPR_WM_RESP;
          to_cnt_d = '0;
        end else begin
          if (to_cnt_q != ToW'(GNT_TIMEOUT - 1)) to_cnt_d = to_cnt_q + ToW'(1);
          if (to_cnt_q == ToW'(GNT_TIMEOUT - 1)) err_to_set = 1'b1;
        end
      end
      IPR_WM_RESP: begin
        if (ipr.rvalid) begin
          words_d = words_q + 32'd1;
          if (bulk_cnt_q == BulkW'(BULK_NUMBER - 1)) begin
            bulk_cnt_d  = '0;
            bulk_done_d = 1'b1;
          end else begin
            bulk_cnt_d = bulk_cnt_q + BulkW'(1);
          end
        end else begin
          err_pr_set = 1'b1;
        end
        state_d = (en && !buf_empty) ? IPR_WM_REQ : IPR_WM_IDLE;
      end
      default: state_d = IPR_WM_IDLE;
    endcase
    // Set wins over a simultaneous clear.
    err_to_d = err_to_set || (err_to_q && !err_clr);
    err_pr_d = err_pr_set || (err_pr_q && !err_clr);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q     <= IPR_WM_IDLE;
      req_q       <= 1'b0;
      to_cnt_q    <= '0;
      bulk_cnt_q  <= '0;
      bulk_done_q <= 1'b0;
      words_q     <= '0;
      err_to_q    <= 1'b0;
      err_pr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= (state_d == IPR_WM_REQ);
      to_cnt_q    <= to_cnt_d;
      bulk_cnt_q  <= bulk_cnt_d;
      bulk_done_q <= bulk_done_d;
      words_q     <= words_d;
      err_to_q    <= err_to_d;
      err_pr_q    <= err_pr_d;
    end
  end

  assign ipr.req     = req_q;
  assign ipr.we      = req_q;
  assign ipr.addr    = req_q ? ipr_reg_addr(BASE_ADDR, IPR_REG_DATA) : 32'h0;
  assign ipr.wdata   = req_q ? buf_head : '0;
  assign busy        = (state_q != IPR_WM_IDLE) || !buf_empty;
  assign bulk_done   = bulk_done_q;
  assign words_sent  = words_q;
  assign err_timeout = err_to_q;
  assign err_proto   = err_pr_q;

endmodule

// File: tb/tb_ipr_write_master.sv
// Bench for ipr_write_master: behavioural responder plus a word scoreboard and counters.
module tb_ipr_write_master;

  localparam logic [31:0] Base = 32'h4000_1000;

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        en;
  logic        err_clr;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        s_ready, busy, bulk_done, err_timeout, err_proto;
  logic [31:0] words_sent;

  ipr_write_master_if #(.DATA_W(32)) ipr_bus ();

  ipr_write_master #(
    .DATA_W      (32),
    .BASE_ADDR   (Base),
    .BULK_NUMBER (10),
    .GNT_TIMEOUT (256)
  ) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .en          (en),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .ipr         (ipr_bus),
    .busy        (busy),
    .bulk_done   (bulk_done),
    .words_sent  (words_sent),
    .err_timeout (err_timeout),
    .err_proto   (err_proto),
    .err_clr     (err_clr)
  );

  always #5 w_clk = ~w_clk;

  int errors = 0;
  int checks = 0;

  // Main block raises *_req / words_queued; the responder process owns the *_done counters.
  int words_queued = 0, words_pushed = 0;
  int drop_req = 0, drop_done = 0;
  int once_req = 0, once_done = 0;
  int stray_req = 0, stray_done = 0;
  int gnt_mode = 1;  // 0 random, 1 always, 2 never
  bit dense = 1'b1;
  bit rate_on = 1'b0;

  logic [31:0] model_q[$];
  int   words_exp = 0, bulk_model = 0, bulk_pulses = 0, gnt_total = 0;
  int   cyc_n = 0, prev_gnt_cyc = -1;
  logic bulk_exp = 1'b0;

  bit          push_seen, gnt_seen;
  logic [31:0] push_data_seen, gnt_data_seen, gnt_addr_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge w_clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while ((busy || words_pushed != words_queued) && n < bound) begin
      tick(1);
      n++;
    end
    check_eq(tag, {31'b0, busy || (words_pushed != words_queued)}, 0);
  endtask

  task automatic wait_gnt(input string tag, input int bound);
    int g0 = gnt_total;
    int n = 0;
    while (gnt_total == g0 && n < bound) begin
      tick(1);
      n++;
    end
    check_eq(tag, {31'b0, gnt_total != g0}, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_s_ready"}, s_ready, 0);
    check_eq({tag, "_req"}, ipr_bus.req, 0);
    check_eq({tag, "_we"}, ipr_bus.we, 0);
    check_eq({tag, "_addr"}, ipr_bus.addr, 0);
    check_eq({tag, "_wdata"}, ipr_bus.wdata, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_bulk_done"}, bulk_done, 0);
    check_eq({tag, "_words_sent"}, words_sent, 0);
    check_eq({tag, "_err_timeout"}, err_timeout, 0);
    check_eq({tag, "_err_proto"}, err_proto, 0);
  endtask

  // Handshakes are judged mid-cycle, where every DUT output and bench input is stable.
  always @(negedge w_clk) begin
    push_seen      = s_valid && s_ready && w_rst_n;
    push_data_seen = s_data;
    gnt_seen       = ipr_bus.req && ipr_bus.gnt && w_rst_n;
    gnt_data_seen  = ipr_bus.wdata;
    gnt_addr_seen  = ipr_bus.addr;
  end

  // Responder, stream source and reference model, all stepping just after each edge.
  always @(posedge w_clk) begin
    #1;
    cyc_n++;
    if (!w_rst_n) begin
      model_q.delete();
      words_exp      = 0;
      bulk_model     = 0;
      bulk_exp       = 1'b0;
      ipr_bus.gnt    = 1'b0;
      ipr_bus.rvalid = 1'b0;
      s_valid        = 1'b0;
      words_pushed   = words_queued;
    end else begin
      check_eq("bulk_done", bulk_done, bulk_exp);
      if (bulk_done) bulk_pulses++;
      check_eq("words_sent", words_sent, words_exp);
      if (gnt_seen) begin
        gnt_total++;
        check_eq("addr", gnt_addr_seen, Base);
        if (model_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wdata: got %0h with no word outstanding", gnt_data_seen);
        end else begin
          check_eq("wdata", gnt_data_seen, model_q.pop_front());
        end
        if (rate_on && prev_gnt_cyc >= 0) check_eq("gnt_spacing", cyc_n - prev_gnt_cyc, 2);
        prev_gnt_cyc = cyc_n;
      end
      if (push_seen) begin
        model_q.push_back(push_data_seen);
        words_pushed++;
      end
      bulk_exp       = 1'b0;
      ipr_bus.rvalid = 1'b0;
      if (gnt_seen) begin
        if (drop_done != drop_req) begin
          drop_done++;
        end else begin
          ipr_bus.rvalid = 1'b1;
          words_exp++;
          bulk_model = (bulk_model + 1) % 10;
          bulk_exp   = (bulk_model == 0);
        end
      end else if (stray_done != stray_req && !ipr_bus.req) begin
        ipr_bus.rvalid = 1'b1;
        stray_done++;
      end
      ipr_bus.gnt = 1'b0;
      if (ipr_bus.req) begin
        if (once_done != once_req) begin
          ipr_bus.gnt = 1'b1;
          once_done++;
        end else if (gnt_mode == 1) begin
          ipr_bus.gnt = 1'b1;
        end else if (gnt_mode == 0) begin
          ipr_bus.gnt = ($urandom_range(9) < 7);
        end
      end
      if (words_pushed < words_queued) begin
        if (!s_valid || push_seen) begin
          s_valid = dense || ($urandom_range(3) != 0);
          s_data  = $urandom;
        end
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    w_rst_n = 1'b0;
    en      = 1'b0;
    err_clr = 1'b0;
    tick(2);
    check_all_zero("reset");
    w_rst_n = 1'b1;
    tick(1);
    check_eq("s_ready_after_reset", s_ready, 1);
    en = 1'b1;

    // Three words at full rate.
    gnt_mode = 1;
    dense    = 1'b1;
    rate_on  = 1'b1;
    words_queued += 3;
    wait_idle("t1_idle", 200);
    rate_on = 1'b0;
    check_eq("t1_words", words_sent, 3);
    check_eq("t1_err_proto", err_proto, 0);
    check_eq("t1_err_timeout", err_timeout, 0);

    // One bulk of ten.
    begin
      int b0 = bulk_pulses;
      words_queued += 10;
      wait_idle("t2_idle", 200);
      tick(2);
      check_eq("t2_bulk_pulses", bulk_pulses - b0, 1);
      check_eq("t2_words", words_sent, 13);
    end

    // Grant timeout.
    begin
      int n = 0;
      gnt_mode = 2;
      words_queued += 1;
      while (!ipr_bus.req && n < 20) begin
        tick(1);
        n++;
      end
      check_eq("t3_req_up", ipr_bus.req, 1);
      tick(255);
      check_eq("t3_no_timeout_yet", err_timeout, 0);
      tick(1);
      check_eq("t3_timeout", err_timeout, 1);
      check_eq("t3_req_held", ipr_bus.req, 1);
      check_eq("t3_we", ipr_bus.we, 1);
      tick(43);
      check_eq("t3_req_held_300", ipr_bus.req, 1);
      check_eq("t3_wdata_hold", ipr_bus.wdata, model_q[0]);
      gnt_mode = 1;
      wait_idle("t3_idle", 20);
      check_eq("t3_timeout_sticky", err_timeout, 1);
      check_eq("t3_words", words_sent, 14);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check_eq("t3_timeout_cleared", err_timeout, 0);
    end

    // Missing response, then stray responses in idle.
    drop_req++;
    words_queued += 1;
    wait_idle("t4_idle", 50);
    tick(1);
    check_eq("t4_err_proto", err_proto, 1);
    check_eq("t4_words", words_sent, 14);
    stray_req++;
    tick(3);
    check_eq("t4_proto_stays", err_proto, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("t4_proto_cleared", err_proto, 0);
    stray_req++;
    tick(3);
    check_eq("t4_stray_sets", err_proto, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check_eq("t4_proto_cleared2", err_proto, 0);

    // Full buffer, en dropped during REQ.
    gnt_mode = 2;
    words_queued += 2;
    tick(8);
    check_eq("t5_full_not_ready", s_ready, 0);
    check_eq("t5_req", ipr_bus.req, 1);
    en = 1'b0;
    once_req++;
    wait_gnt("t5_gnt", 20);
    check_eq("t5_ready_after_pop", s_ready, 1);
    tick(4);
    check_eq("t5_idle_req", ipr_bus.req, 0);
    check_eq("t5_busy_word_left", busy, 1);
    check_eq("t5_words", words_sent, 15);
    en = 1'b1;
    gnt_mode = 1;
    wait_idle("t5_idle", 50);
    check_eq("t5_words_final", words_sent, 16);

    // Reset in the response cycle.
    words_queued += 2;
    wait_gnt("t6_gnt", 20);
    w_rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    tick(2);
    w_rst_n = 1'b1;
    tick(1);
    check_eq("t6_s_ready", s_ready, 1);
    tick(5);
    check_eq("t6_no_req", ipr_bus.req, 0);
    check_eq("t6_not_busy", busy, 0);
    words_queued += 1;
    wait_idle("t6_idle", 50);
    check_eq("t6_words", words_sent, 1);

    // Randomised traffic with random grants, stream gaps and en toggling.
    begin
      int n = 0;
      gnt_mode = 0;
      dense    = 1'b0;
      words_queued += 60;
      while ((busy || words_pushed != words_queued) && n < 3000) begin
        en = ($urandom_range(7) != 0);
        tick(1);
        n++;
      end
      en = 1'b1;
      wait_idle("rand_idle", 500);
      tick(2);
      check_eq("rand_words_model", words_sent, words_exp);
      check_eq("rand_words", words_sent, 61);
      check_eq("rand_queue_empty", model_q.size(), 0);
      check_eq("rand_err_timeout", err_timeout, 0);
      check_eq("rand_err_proto", err_proto, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
